flexbex_instr_bus_arbiter: RTL and testbench

- Shares one instruction-memory port between NUM_MASTERS fetch masters, e.g. two flexbex cores' prefetch buffers, or a core plus a debug/DMA fetcher.
- Each side uses the core's instruction-bus handshake: req/addr held until gnt; rvalid/rdata arrive in order, at least 1 cycle after gnt.
- Arbitration is round-robin with grant locking.
- An in-order ID FIFO routes each response back to the master that issued the request.

---
 rtl/flexbex_arb_pkg.sv | 33 +++
 rtl/flexbex_arb_id_fifo.sv | 75 +++++++
 rtl/flexbex_instr_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_flexbex_instr_bus_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/flexbex_arb_pkg.sv
// flexbex_arb_pkg
//   Shared types and helpers for the flexbex instruction-bus arbiter.
//   ARB_MAX_MASTERS : upper bound on the number of fetch masters
//   arb_id_t        : master index wide enough for ARB_MAX_MASTERS
//   rr_pick()       : circular first-set search used for round-robin selection
package flexbex_arb_pkg;

  localparam int ARB_MAX_MASTERS = 8;

  typedef logic [2:0] arb_id_t;

  // Returns the first index with req set, searching upward from ptr and
  // wrapping. Request vectors narrower than ARB_MAX_MASTERS are zero-padded,
  // so the 3-bit wrap behaves like a wrap modulo the real master count.
  // With no request set the result is ptr (the caller ignores it then).
  function automatic arb_id_t rr_pick(input logic [ARB_MAX_MASTERS-1:0] req,
                                      input arb_id_t                    ptr);
    arb_id_t idx;
    arb_id_t pick;
    logic    found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < ARB_MAX_MASTERS; k++) begin
      idx = ptr + arb_id_t'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/flexbex_arb_id_fifo.sv
// flexbex_arb_id_fifo
//   In-order FIFO of master indices, one entry per granted-but-unanswered
//   memory transaction. The head tells the arbiter which master owns the
//   next response.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : store data_i (caller guarantees !full_o)
//   data_i     : master index to store
//   pop_i      : discard head (caller guarantees !empty_o)
//   head_o     : oldest stored index
//   empty_o    : no entries
//   full_o     : DEPTH entries stored
module flexbex_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_i) begin
      wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
    end
    if (push_i && !pop_i) begin
      count_next = count_reg + CW'(1);
    end else if (!push_i && pop_i) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem[wr_ptr_reg] <= data_i;
    end
  end

  assign head_o  = mem[rd_ptr_reg];
  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/flexbex_instr_bus_arbiter.sv
// flexbex_instr_bus_arbiter
//   Shares one instruction-memory port between NUM_MASTERS fetch masters.
//   Round-robin arbitration with grant locking (address held stable until
//   the memory grants); an ID FIFO routes in-order responses back.
//   Optional macro FLEXBEX_ARB_PRIO_EN: master 0 gets strict priority and
//   masters 1..N-1 rotate among themselves.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     m_req_i / m_addr_i    : per-master request and 32-bit address
//     m_gnt_o / m_rvalid_o  : per-master grant and response valid
//     m_rdata_o             : response data, broadcast to all masters
//     mem_req_o/mem_addr_o  : memory request and address
//     mem_gnt_i             : memory grant
//     mem_rvalid_i/rdata_i  : memory response
//     busy_o                : transactions outstanding or any request pending
//     err_o                 : sticky protocol error
module flexbex_instr_bus_arbiter
  import flexbex_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    m_req_i,
  input  logic [32*NUM_MASTERS-1:0] m_addr_i,
  output logic [NUM_MASTERS-1:0]    m_gnt_o,
  output logic [NUM_MASTERS-1:0]    m_rvalid_o,
  output logic [31:0]               m_rdata_o,
  output logic                      mem_req_o,
  output logic [31:0]               mem_addr_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [31:0]               mem_rdata_i,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int IDW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

`ifdef FLEXBEX_ARB_PRIO_EN
  localparam arb_id_t RR_RESET = arb_id_t'(1);
`else
  localparam arb_id_t RR_RESET = arb_id_t'(0);
`endif

  logic                       lock_reg, lock_next;
  arb_id_t                    locked_id_reg, locked_id_next;
  arb_id_t                    rr_ptr_reg, rr_ptr_next;
  logic                       err_reg, err_next;

  logic [ARB_MAX_MASTERS-1:0] req_ext;
  arb_id_t                    sel;
  logic [31:0]                sel_addr;
  logic                       lock_drop;
  logic                       grant;
  logic                       pop;
  logic                       fifo_empty, fifo_full;
  logic [IDW-1:0]             fifo_head;

  assign req_ext = ARB_MAX_MASTERS'(m_req_i);

  // Selection: a locked grant wins; otherwise rotate from rr_ptr.
  always_comb begin
    sel = locked_id_reg;
    if (!lock_reg) begin
`ifdef FLEXBEX_ARB_PRIO_EN
      sel = m_req_i[0] ? arb_id_t'(0) : rr_pick({req_ext[ARB_MAX_MASTERS-1:1], 1'b0}, rr_ptr_reg);
`else
      sel = rr_pick(req_ext, rr_ptr_reg);
`endif
    end
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel == arb_id_t'(i)) begin
        sel_addr = m_addr_i[32*i +: 32];
      end
    end
  end

  // A locked master that withdraws its request breaks the bus protocol.
  // The request to memory is suppressed too, so the memory cannot grant a
  // transaction that nobody would push into the ID FIFO.
  assign lock_drop  = lock_reg & ~req_ext[locked_id_reg];
  assign mem_req_o  = (|m_req_i) & ~fifo_full & ~lock_drop;
  assign mem_addr_o = mem_req_o ? sel_addr : 32'h0;
  assign grant      = mem_req_o & mem_gnt_i;
  assign pop        = mem_rvalid_i & ~fifo_empty;

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_gnt_o[i]    = grant && (sel == arb_id_t'(i));
      m_rvalid_o[i] = pop && (fifo_head == IDW'(i));
    end
  end

  assign m_rdata_o = mem_rdata_i;
  assign busy_o    = ~fifo_empty | (|m_req_i);
  assign err_o     = err_reg;

  // Next-state logic for lock, round-robin pointer and error flag.
  always_comb begin
    lock_next      = lock_reg;
    locked_id_next = locked_id_reg;
    rr_ptr_next    = rr_ptr_reg;
    err_next       = err_reg;

    if (lock_drop) begin
      lock_next = 1'b0;
      err_next  = 1'b1;
    end else if (mem_req_o && !mem_gnt_i) begin
      lock_next      = 1'b1;
      locked_id_next = sel;
    end else if (grant) begin
      lock_next = 1'b0;
    end

    if (grant) begin
`ifdef FLEXBEX_ARB_PRIO_EN
      if (sel != arb_id_t'(0)) begin
        rr_ptr_next = (sel == arb_id_t'(NUM_MASTERS - 1)) ? arb_id_t'(1) : sel + arb_id_t'(1);
      end
`else
      rr_ptr_next = (sel == arb_id_t'(NUM_MASTERS - 1)) ? arb_id_t'(0) : sel + arb_id_t'(1);
`endif
    end

    if (mem_rvalid_i && fifo_empty) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_reg      <= 1'b0;
      locked_id_reg <= '0;
      rr_ptr_reg    <= RR_RESET;
      err_reg       <= 1'b0;
    end else begin
      lock_reg      <= lock_next;
      locked_id_reg <= locked_id_next;
      rr_ptr_reg    <= rr_ptr_next;
      err_reg       <= err_next;
    end
  end

  flexbex_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDW)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant),
    .data_i  (sel[IDW-1:0]),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_flexbex_instr_bus_arbiter.sv
// tb_flexbex_instr_bus_arbiter
//   Directed bench for the instruction-bus arbiter (NUM_MASTERS=2,
//   MAX_OUTSTANDING=2). A table of per-cycle vectors covers round-robin,
//   locking, FIFO-full and spurious-response behaviour; hand-written
//   sequences cover reset mid-burst and an illegal request drop.
//   Built with FLEXBEX_ARB_PRIO_EN it runs a priority sequence instead.
module tb_flexbex_instr_bus_arbiter;

  localparam int N   = 2;
  localparam int MAX = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req_i;
  logic [32*N-1:0] m_addr_i;
  logic [N-1:0]    m_gnt_o;
  logic [N-1:0]    m_rvalid_o;
  logic [31:0]     m_rdata_o;
  logic            mem_req_o;
  logic [31:0]     mem_addr_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [31:0]     mem_rdata_i;
  logic            busy_o;
  logic            err_o;

  flexbex_instr_bus_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (MAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_req_i      (m_req_i),
    .m_addr_i     (m_addr_i),
    .m_gnt_o      (m_gnt_o),
    .m_rvalid_o   (m_rvalid_o),
    .m_rdata_o    (m_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                              input logic gnt, input logic rv, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr, input logic [1:0] e_gnt,
                              input logic [1:0] e_rv, input logic e_busy, input logic e_err);
    vec_t v;
    v.req = req; v.a0 = a0; v.a1 = a1; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_gnt = e_gnt; v.e_rv = e_rv;
    v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                       input logic gnt, input logic rv, input logic [31:0] rd);
    m_req_i      = req;
    m_addr_i     = {a1, a0};
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

`ifdef FLEXBEX_ARB_PRIO_EN
    // Master 0 wins every unlocked grant; master 1 only when 0 is idle.
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("prio_c1_gnt", 32'(m_gnt_o), 32'h1);
    step();
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hA0);
    chk("prio_c2_gnt", 32'(m_gnt_o), 32'h1);
    chk("prio_c2_rv", 32'(m_rvalid_o), 32'h1);
    step();
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b1, 32'hA0);
    chk("prio_c3_gnt", 32'(m_gnt_o), 32'h1);
    step();
    drive(2'b10, 32'h100, 32'h200, 1'b1, 1'b1, 32'hA0);
    chk("prio_c4_gnt", 32'(m_gnt_o), 32'h2);
    chk("prio_c4_addr", mem_addr_o, 32'h200);
    step();
    drive(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'hB1);
    chk("prio_c5_rv", 32'(m_rvalid_o), 32'h2);
    chk("prio_c5_err", 32'(err_o), 32'h0);
    step();
    drive(2'b00, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("prio_idle_busy", 32'(busy_o), 32'h0);
`else
    // Reset state
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 0, 32'h0,  0, 32'h0,   2'b00, 2'b00, 0, 0));
    // Basic round-robin: grants 0,1,0,1, responses routed per tag
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 0, 32'h0,  1, 32'h100, 2'b01, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 1, 32'hA0, 1, 32'h200, 2'b10, 2'b01, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 1, 32'hB1, 1, 32'h100, 2'b01, 2'b10, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 1, 32'hA0, 1, 32'h200, 2'b10, 2'b01, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 1, 32'hB1, 0, 32'h0,   2'b00, 2'b10, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 0, 32'h0,  0, 32'h0,   2'b00, 2'b00, 0, 0));
    // Lock: master 1 waits 3 cycles at 0x1000, master 0 joins, grant in cycle 4
    vecs.push_back(mk(2'b10, 32'h100, 32'h1000, 0, 0, 32'h0,  1, 32'h1000, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h1000, 0, 0, 32'h0,  1, 32'h1000, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h1000, 0, 0, 32'h0,  1, 32'h1000, 2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h1000, 1, 0, 32'h0,  1, 32'h1000, 2'b10, 2'b00, 1, 0));
    vecs.push_back(mk(2'b01, 32'h100, 32'h1000, 1, 1, 32'hB1, 1, 32'h100,  2'b01, 2'b10, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h1000, 0, 1, 32'hA0, 0, 32'h0,    2'b00, 2'b01, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h1000, 0, 0, 32'h0,  0, 32'h0,    2'b00, 2'b00, 0, 0));
    // FIFO full: two grants, request stalls, one response reopens it next cycle
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 0, 32'h0,  1, 32'h200, 2'b10, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 0, 32'h0,  1, 32'h100, 2'b01, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 0, 32'h0,  0, 32'h0,   2'b00, 2'b00, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 1, 32'hB1, 0, 32'h0,   2'b00, 2'b10, 1, 0));
    vecs.push_back(mk(2'b11, 32'h100, 32'h200, 1, 0, 32'h0,  1, 32'h200, 2'b10, 2'b00, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 1, 32'hA0, 0, 32'h0,   2'b00, 2'b01, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 1, 32'hB1, 0, 32'h0,   2'b00, 2'b10, 1, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 0, 32'h0,  0, 32'h0,   2'b00, 2'b00, 0, 0));
    // Spurious rvalid with empty FIFO: no routed response, sticky error
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 1, 32'hEE, 0, 32'h0,   2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(2'b00, 32'h100, 32'h200, 0, 0, 32'h0,  0, 32'h0,   2'b00, 2'b00, 0, 1));
    vecs.push_back(mk(2'b01, 32'h100, 32'h200, 1, 0, 32'h0,  1, 32'h100, 2'b01, 2'b00, 1, 1));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].gnt, vecs[i].rv, vecs[i].rd);
      chk($sformatf("v%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].e_addr);
      chk($sformatf("v%0d_m_gnt", i), 32'(m_gnt_o), 32'(vecs[i].e_gnt));
      chk($sformatf("v%0d_m_rvalid", i), 32'(m_rvalid_o), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rdata", i), m_rdata_o, vecs[i].rd);
      chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_err));
      $display("vec %0d: req=%b gnt=%b rvalid=%b addr=0x%0h err=%b",
               i, vecs[i].req, m_gnt_o, m_rvalid_o, mem_addr_o, err_o);
      step();
    end

    // Reset mid-burst: second outstanding grant, then reset with a response in flight
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("rst_pre_gnt", 32'(m_gnt_o), 32'h2);
    step();
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("rst_full_req", 32'(mem_req_o), 32'h0);
    rst_n = 1'b0;
    drive(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h77);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_rvalid", 32'(m_rvalid_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    step();
    rst_n = 1'b1;
    drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("post_rst_gnt", 32'(m_gnt_o), 32'h1);
    chk("post_rst_addr", mem_addr_o, 32'h100);
    step();
    drive(2'b00, 32'h100, 32'h200, 1'b0, 1'b1, 32'h5A);
    chk("post_rst_rv", 32'(m_rvalid_o), 32'h1);
    step();
    drive(2'b00, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("post_rst_err", 32'(err_o), 32'h0);
    chk("post_rst_busy", 32'(busy_o), 32'h0);
    $display("reset mid-burst sequence done");

    // Locked master drops its request: no grant, error raised, lock released
    drive(2'b10, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0);
    chk("drop_lock_req", 32'(mem_req_o), 32'h1);
    step();
    drive(2'b01, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("drop_no_gnt", 32'(m_gnt_o), 32'h0);
    step();
    drive(2'b01, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("drop_err", 32'(err_o), 32'h1);
    chk("drop_next_gnt", 32'(m_gnt_o), 32'h1);
    step();
    $display("lock drop sequence done");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
